// File: rtl/irq_encoder_8_3.sv
// Registered 8-to-3 priority interrupt encoder with mask and IRQ/ACK/EOI handshake.
// Define IRQ_EDGE_EN for rising-edge request capture; default build is level-triggered.
module irq_encoder_8_3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       E,
    input  logic [7:0] R,
    input  logic       MASK_WE,
    input  logic [7:0] MASK_IN,
    input  logic       ACK,
    input  logic       EOI,
    output logic       IRQ,
    output logic [2:0] VEC,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] pend;
    logic [7:0] mask;
    logic [7:0] req_events;
    logic [7:0] eligible;
    logic [7:0] clr;
    logic [2:0] top_idx;

`ifdef IRQ_EDGE_EN
    logic [7:0] rprev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rprev <= '0;
        else     rprev <= R;
    end

    assign req_events = R & ~rprev;
`else
    assign req_events = R;
`endif

    assign eligible = pend & ~mask;
    assign clr      = (state == REQ && ACK) ? (8'b1 << VEC) : 8'b0;

    // Ascending scan: the last (highest) eligible index overwrites lower ones.
    always_comb begin
        top_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (eligible[i]) top_idx = 3'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pend  <= '0;
            mask  <= '0;
            VEC   <= '0;
        end else begin
            state <= state_next;
            // Set wins over ACK clear on the same bit.
            pend  <= (pend & ~clr) | req_events;
            if (MASK_WE) mask <= MASK_IN;
            if (state == IDLE && state_next == REQ) VEC <= top_idx;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (E && (eligible != 8'b0)) state_next = REQ;
            REQ:     if (ACK) state_next = SERVICE;
                     else if (!E) state_next = IDLE;
            SERVICE: if (EOI) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode the state register only, so no input reaches them combinationally.
    always_comb begin
        IRQ  = (state == REQ);
        BUSY = (state == SERVICE);
    end

endmodule
